ioctl_wb_loader: RTL and testbench

- Downstream of hps_io's ioctl download port, upstream of the SDRAM wishbone arbiter.
- Packs 16-bit ioctl download halfwords (RISC OS ROM, index 1) into 32-bit wishbone writes to SDRAM at a fixed base offset.
- Back-pressures hps_io with ioctl_wait while a bus write is outstanding.
- Provides an `active` flag so the top level can steer the SDRAM mux away from the CPU during download.

---
 rtl/ioctl_wb_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_ioctl_wb_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_wb_loader.sv
// Packs 16-bit hps_io download halfwords into 32-bit wishbone writes to SDRAM.
// Latency: wb_stb rises on the edge after the accepted ioctl_wr and drops on the edge after wb_ack.
// Backpressure: ioctl_wait is held high while any bus write is in flight. It has no timeout.
module ioctl_wb_loader #(
    parameter logic [7:0]  DL_INDEX  = 8'd1,
    parameter logic [25:0] BASE_ADDR = 26'h0400000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [25:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack,
    output logic        active,
    output logic        done,
    output logic [22:0] word_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_WRITE2 = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    // Byte address of a 32-bit word slot, relative to the download base (wraps at 26 bits).
    function automatic logic [25:0] word_addr(input logic [22:0] a);
        return BASE_ADDR + {1'b0, a, 2'b00};
    endfunction

    logic [1:0]  state_q, state_d;
    logic        stb_q, stb_d;
    logic [25:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;

    // Second write queued behind the current one (mismatched high half).
    logic        q2_vld_q, q2_vld_d;
    logic [25:0] q2_adr_q, q2_adr_d;
    logic [31:0] q2_dat_q, q2_dat_d;

    // Pending-low register: a low halfword waiting for its high partner.
    logic        pl_vld_q, pl_vld_d;
    logic [22:0] pl_adr_q, pl_adr_d;
    logic [15:0] pl_dat_q, pl_dat_d;

    logic        active_q, active_d;
    logic        eod_q, eod_d;
    logic        done_q, done_d;
    logic [22:0] cnt_q, cnt_d;

    logic        act_rise;
    logic        act_fall;
    logic        accept;
    logic        pl_vld_cur;
    logic [22:0] cnt_cur;
    logic [22:0] a_word;
    logic        unused_addr0;

    assign active       = ioctl_download & (ioctl_index == DL_INDEX);
    assign act_rise     = active & ~active_q;
    assign act_fall     = ~active & active_q;
    assign accept       = ioctl_wr & active & (state_q == S_IDLE);
    assign a_word       = ioctl_addr[24:2];
    assign unused_addr0 = ioctl_addr[0];

    // A new download starts from an empty pending-low register and a zero count.
    assign pl_vld_cur = pl_vld_q & ~act_rise;
    assign cnt_cur    = act_rise ? 23'd0 : cnt_q;

    // Next-state: write decode in IDLE, handshake tracking in the bus states.
    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        q2_vld_d = q2_vld_q;
        q2_adr_d = q2_adr_q;
        q2_dat_d = q2_dat_q;
        pl_vld_d = pl_vld_cur;
        pl_adr_d = pl_adr_q;
        pl_dat_d = pl_dat_q;
        active_d = active;
        eod_d    = eod_q | act_fall;
        done_d   = 1'b0;
        cnt_d    = cnt_cur;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!ioctl_addr[1]) begin
                        // Low half: flush any stale low half, then park the new one.
                        if (pl_vld_cur) begin
                            state_d = S_WRITE;
                            stb_d   = 1'b1;
                            adr_d   = word_addr(pl_adr_q);
                            sel_d   = 4'b0011;
                            dat_d   = {16'h0, pl_dat_q};
                        end
                        pl_vld_d = 1'b1;
                        pl_adr_d = a_word;
                        pl_dat_d = ioctl_dout;
                    end else if (pl_vld_cur && (pl_adr_q == a_word)) begin
                        // Matching pair: one full-word write.
                        state_d  = S_WRITE;
                        stb_d    = 1'b1;
                        adr_d    = word_addr(a_word);
                        sel_d    = 4'b1111;
                        dat_d    = {ioctl_dout, pl_dat_q};
                        pl_vld_d = 1'b0;
                    end else if (pl_vld_cur) begin
                        // Mismatched pair: stale low half now, high half queued behind it.
                        state_d  = S_WRITE;
                        stb_d    = 1'b1;
                        adr_d    = word_addr(pl_adr_q);
                        sel_d    = 4'b0011;
                        dat_d    = {16'h0, pl_dat_q};
                        q2_vld_d = 1'b1;
                        q2_adr_d = word_addr(a_word);
                        q2_dat_d = {ioctl_dout, 16'h0};
                        pl_vld_d = 1'b0;
                    end else begin
                        // Lone high half.
                        state_d = S_WRITE;
                        stb_d   = 1'b1;
                        adr_d   = word_addr(a_word);
                        sel_d   = 4'b1100;
                        dat_d   = {ioctl_dout, 16'h0};
                    end
                end else if (eod_q || act_fall) begin
                    // End of download: drain a parked low half, else signal done now.
                    eod_d = 1'b0;
                    if (pl_vld_cur) begin
                        state_d  = S_FLUSH;
                        stb_d    = 1'b1;
                        adr_d    = word_addr(pl_adr_q);
                        sel_d    = 4'b0011;
                        dat_d    = {16'h0, pl_dat_q};
                        pl_vld_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (stb_q && wb_ack) begin
                    stb_d = 1'b0;
                    cnt_d = cnt_cur + 23'd1;
                    if (q2_vld_q) begin
                        // Strobe stays low for one cycle before the queued write.
                        state_d  = S_WRITE2;
                        adr_d    = q2_adr_q;
                        sel_d    = 4'b1100;
                        dat_d    = q2_dat_q;
                        q2_vld_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_WRITE2: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (wb_ack) begin
                    stb_d   = 1'b0;
                    cnt_d   = cnt_cur + 23'd1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                if (stb_q && wb_ack) begin
                    stb_d   = 1'b0;
                    cnt_d   = cnt_cur + 23'd1;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // State registers; reset overrides any coincident ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            stb_q    <= 1'b0;
            adr_q    <= 26'd0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            q2_vld_q <= 1'b0;
            q2_adr_q <= 26'd0;
            q2_dat_q <= 32'd0;
            pl_vld_q <= 1'b0;
            pl_adr_q <= 23'd0;
            pl_dat_q <= 16'd0;
            active_q <= 1'b0;
            eod_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 23'd0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            q2_vld_q <= q2_vld_d;
            q2_adr_q <= q2_adr_d;
            q2_dat_q <= q2_dat_d;
            pl_vld_q <= pl_vld_d;
            pl_adr_q <= pl_adr_d;
            pl_dat_q <= pl_dat_d;
            active_q <= active_d;
            eod_q    <= eod_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb_stb     = stb_q;
    assign wb_cyc     = stb_q;
    assign wb_we      = stb_q;
    assign wb_sel     = sel_q;
    assign wb_adr     = adr_q;
    assign wb_dat_o   = dat_q;
    assign ioctl_wait = (state_q != S_IDLE);
    assign done       = done_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_ioctl_wb_loader.sv
// Bench for ioctl_wb_loader: scoreboard of expected wishbone writes, checked at ack time.
// Latency: the responder acks after a programmable stall.
// Backpressure: stimulus waits for ioctl_wait low before each ioctl_wr.
module tb_ioctl_wb_loader;

    typedef struct packed {
        logic [25:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd1;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [15:0] ioctl_dout = 16'd0;
    logic        ioctl_wait;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_ack = 1'b0;
    logic        active, done;
    logic [22:0] word_count;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_ack_cyc = -10;
    int  ack_delay = 0;
    int  stall = 0;
    logic ack_en = 1'b1;
    logic ack_force = 1'b0;

    ioctl_wb_loader dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .active(active), .done(done), .word_count(word_count)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Wishbone responder and scoreboard: compare each write when it is acked.
    always @(negedge clk_sys) begin
        if (!ack_en) begin
            wb_ack = ack_force;
            stall = 0;
        end else if (wb_ack) begin
            wb_ack = 1'b0;
            stall = 0;
        end else if (wb_stb) begin
            if (stall >= ack_delay) begin
                wr_t exp_w;
                wb_ack = 1'b1;
                last_ack_cyc = cyc;
                check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("bus_write", 64'({wb_adr, wb_sel, wb_dat_o}), 64'(exp_w));
                    check("bus_we", 64'({wb_cyc, wb_we}), 64'b11);
                end
            end else begin
                stall++;
            end
        end
    end

    task automatic push(input logic [25:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        wr_t w;
        w.adr = adr; w.sel = sel; w.dat = dat;
        exp_q.push_back(w);
    endtask

    task automatic wr(input logic [24:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(posedge clk_sys); #1;
        while (ioctl_wait && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_sys);
        while ((ioctl_wait || wb_stb) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 64'({wb_stb, ioctl_wait}), 64'd0);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        @(negedge clk_sys); #1;
        while (!wb_ack && n < 100) begin
            @(negedge clk_sys); #1;
            n++;
        end
        check(tag, 64'(wb_ack), 64'd1);
    endtask

    task automatic start_dl;
        @(posedge clk_sys); #1;
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic end_dl(input string tag, output int done_cyc);
        logic got;
        got = 1'b0;
        done_cyc = -1;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_sys);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        check({tag, "_done"}, 64'(got), 64'd1);
        @(negedge clk_sys);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  dc;
        logic saw_stb;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_outputs", 64'({wb_stb, wb_cyc, wb_we, ioctl_wait, done}), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // Paired halfwords -> one full-word write
        start_dl();
        push(26'h0400000, 4'b1111, 32'hABCD1234);
        wr(25'd0, 16'h1234);
        check("low_parked_no_bus", 64'({wb_stb, ioctl_wait}), 64'd0);
        wr(25'd2, 16'hABCD);
        wait_idle("pair_idle");
        check("pair_count", 64'(word_count), 64'd1);
        end_dl("pair", dc);

        // Stalled ack: outputs hold until ack, drop one cycle later
        start_dl();
        ack_delay = 10;
        push(26'h0400020, 4'b1111, 32'hCAFEBEEF);
        wr(25'h20, 16'hBEEF);
        wr(25'h22, 16'hCAFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys); #1;
            check("stall_hold", 64'({wb_stb, ioctl_wait, wb_adr, wb_dat_o}),
                  64'({2'b11, 26'h0400020, 32'hCAFEBEEF}));
        end
        wait_ack("stall_ack");
        @(negedge clk_sys); #1;
        check("stall_drop", 64'({wb_stb, ioctl_wait}), 64'd0);
        ack_delay = 0;
        check("stall_count", 64'(word_count), 64'd1);
        end_dl("stall", dc);

        // Lone high half
        start_dl();
        push(26'h0400004, 4'b1100, 32'h55550000);
        wr(25'd6, 16'h5555);
        wait_idle("lone_idle");
        check("lone_count", 64'(word_count), 64'd1);
        end_dl("lone", dc);

        // Mismatched pair -> two writes with a one-cycle strobe gap
        start_dl();
        push(26'h0400008, 4'b0011, 32'h00001111);
        push(26'h040000C, 4'b1100, 32'h22220000);
        wr(25'd8, 16'h1111);
        wr(25'd14, 16'h2222);
        wait_ack("mis_ack1");
        @(negedge clk_sys); #1;
        check("mis_gap", 64'({wb_stb, ioctl_wait}), 64'b01);
        wait_idle("mis_idle");
        check("mis_count", 64'(word_count), 64'd2);
        end_dl("mis", dc);

        // Trailing flush of a parked low half
        start_dl();
        wr(25'd16, 16'h7777);
        push(26'h0400010, 4'b0011, 32'h00007777);
        end_dl("flush", dc);
        check("flush_done_timing", 64'(dc), 64'(last_ack_cyc + 1));
        check("flush_count", 64'(word_count), 64'd1);

        // Reset mid-write; a late ack must not count
        start_dl();
        ack_en = 1'b0;
        ack_force = 1'b0;
        wr(25'h32, 16'h9999);
        check("rstw_stb_up", 64'(wb_stb), 64'd1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("rstw_drop", 64'({wb_stb, ioctl_wait}), 64'd0);
        check("rstw_count", 64'(word_count), 64'd0);
        reset = 1'b0;
        ack_force = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        ack_force = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rstw_late_ack", 64'({wb_stb, word_count}), 64'd0);
        ack_en = 1'b1;
        end_dl("rstw", dc);

        // Foreign index: no response at all
        @(posedge clk_sys); #1;
        ioctl_index = 8'd3;
        ioctl_download = 1'b1;
        #1;
        check("idx3_inactive", 64'(active), 64'd0);
        wr(25'd2, 16'h4242);
        saw_stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (wb_stb || ioctl_wait) saw_stb = 1'b1;
        end
        check("idx3_no_bus", 64'(saw_stb), 64'd0);
        ioctl_download = 1'b0;

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
